// File: rtl/idct_pkg.sv
// Shared types and constants for the 8x8 inverse DCT engine.
package idct_pkg;

    typedef enum logic [1:0] {LOAD, MAC, OUT} idct_state_t;

    localparam int BLK_N       = 64;
    localparam int LEVEL_SHIFT = 128;
    localparam int PIX_MAX     = 255;

endpackage

// File: rtl/idct_8x8_engine_if.sv
// Coefficient-in / pixel-out stream bundle of the IDCT engine.
// master = block producer / pixel consumer, slave = engine.
interface idct_8x8_engine_if #(
    parameter int COEF_W = 16
);
    logic                     coef_valid;
    logic                     coef_ready;
    logic signed [COEF_W-1:0] coef_data;
    logic                     pix_valid;
    logic                     pix_ready;
    logic [7:0]               pix_data;
    logic                     pix_last;
    logic                     busy;

    modport master (
        output coef_valid, coef_data, pix_ready,
        input  coef_ready, pix_valid, pix_data, pix_last, busy
    );

    modport slave (
        input  coef_valid, coef_data, pix_ready,
        output coef_ready, pix_valid, pix_data, pix_last, busy
    );
endinterface

// File: rtl/idct_sat_round.sv
// Converts a finished accumulator into an 8-bit pixel: round half-up, drop fraction, level-shift, clamp.
module idct_sat_round
    import idct_pkg::*;
#(
    parameter int ACC_W    = 56,
    parameter int COS_FRAC = 16
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic [7:0]              pix
);

    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (COS_FRAC - 1);

    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] leveled;

    always_comb begin
        shifted = (acc + HALF) >>> COS_FRAC;
        leveled = shifted + ACC_W'(LEVEL_SHIFT);
        if (leveled[ACC_W-1])
            pix = 8'd0;
        else if (leveled > ACC_W'(PIX_MAX))
            pix = 8'(PIX_MAX);
        else
            pix = leveled[7:0];
    end

endmodule

// File: rtl/lut_mux.sv
// Shared 2-D cosine basis: C(k1)C(k2)/4 * cos((2n1+1)k1*pi/16) * cos((2n2+1)k2*pi/16), Q16 signed.
module lut_mux (
    input  logic [2:0]         k1,
    input  logic [2:0]         k2,
    input  logic [2:0]         n1,
    input  logic [2:0]         n2,
    output logic signed [31:0] cos_term
);

    // 1-D factor C(k)/2 * cos((2n+1)k*pi/16) in Q16; the angle is folded into 0..16 sixteenths of pi.
    function automatic logic signed [31:0] basis_1d(input logic [2:0] k, input logic [2:0] n);
        logic [4:0] ang;
        ang = {1'b0, n, 1'b1} * {2'b00, k};
        if (ang > 5'd16)
            ang = 5'd0 - ang;
        if (k == 3'd0)
            return 32'sd23170;
        case (ang)
            5'd0:    return  32'sd32768;
            5'd1:    return  32'sd32139;
            5'd2:    return  32'sd30274;
            5'd3:    return  32'sd27246;
            5'd4:    return  32'sd23170;
            5'd5:    return  32'sd18205;
            5'd6:    return  32'sd12540;
            5'd7:    return  32'sd6393;
            5'd9:    return -32'sd6393;
            5'd10:   return -32'sd12540;
            5'd11:   return -32'sd18205;
            5'd12:   return -32'sd23170;
            5'd13:   return -32'sd27246;
            5'd14:   return -32'sd30274;
            5'd15:   return -32'sd32139;
            5'd16:   return -32'sd32768;
            default: return  32'sd0;
        endcase
    endfunction

    logic signed [63:0] mix;

    always_comb begin
        mix      = 64'(basis_1d(k1, n1)) * 64'(basis_1d(k2, n2));
        cos_term = 32'((mix + 64'sd32768) >>> 16);
    end

endmodule

// File: rtl/idct_8x8_engine.sv
// Inverse 2-D DCT of one 8x8 block: buffer 64 coefficients, then one serial 64-term MAC per output pixel.
module idct_8x8_engine
    import idct_pkg::*;
#(
    parameter int COEF_W   = 16,
    parameter int COS_FRAC = 16,
    parameter int ACC_W    = 56
) (
    input  logic               clk,
    input  logic               rst_n,
    idct_8x8_engine_if.slave   bus
);

    localparam int PROD_W = COEF_W + 32;

    idct_state_t              state;
    logic [5:0]               load_cnt;
    logic [5:0]               pix_idx;
    logic [6:0]               mac_cnt;
    logic [5:0]               term_idx;
    logic signed [COEF_W-1:0] coef_buf [BLK_N];
    logic signed [31:0]       cos_term;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic [7:0]               pix_next;
    logic                     coef_hs;
    logic                     pix_hs;

    assign term_idx = mac_cnt[5:0];
    assign coef_hs  = bus.coef_valid && bus.coef_ready;
    assign pix_hs   = bus.pix_valid && bus.pix_ready;
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    // Stage 2 trails stage 1 by a cycle, so the first product lands when mac_cnt is 1.
    assign acc_next = (mac_cnt == 7'd1) ? prod_ext : acc + prod_ext;

    lut_mux u_lut (
        .k1       (term_idx[5:3]),
        .k2       (term_idx[2:0]),
        .n1       (pix_idx[5:3]),
        .n2       (pix_idx[2:0]),
        .cos_term (cos_term)
    );

    idct_sat_round #(
        .ACC_W    (ACC_W),
        .COS_FRAC (COS_FRAC)
    ) u_sat (
        .acc (acc_next),
        .pix (pix_next)
    );

    always_ff @(posedge clk) begin
        if (state == LOAD && coef_hs)
            coef_buf[load_cnt] <= bus.coef_data;
    end

    // The drain cycle (mac_cnt == 64) folds in the last product and registers the finished pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= LOAD;
            load_cnt       <= '0;
            pix_idx        <= '0;
            mac_cnt        <= '0;
            prod           <= '0;
            acc            <= '0;
            bus.coef_ready <= 1'b1;
            bus.pix_valid  <= 1'b0;
            bus.pix_data   <= '0;
            bus.pix_last   <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (coef_hs) begin
                        load_cnt <= load_cnt + 6'd1;
                        if (load_cnt == 6'd63) begin
                            state          <= MAC;
                            pix_idx        <= '0;
                            mac_cnt        <= '0;
                            bus.coef_ready <= 1'b0;
                            bus.busy       <= 1'b1;
                        end
                    end
                end
                MAC: begin
                    if (!mac_cnt[6])
                        prod <= PROD_W'(coef_buf[term_idx]) * PROD_W'(cos_term);
                    if (mac_cnt != 7'd0)
                        acc <= acc_next;
                    if (mac_cnt == 7'd64) begin
                        state         <= OUT;
                        bus.pix_data  <= pix_next;
                        bus.pix_valid <= 1'b1;
                        bus.pix_last  <= (pix_idx == 6'd63);
                    end else begin
                        mac_cnt <= mac_cnt + 7'd1;
                    end
                end
                OUT: begin
                    if (pix_hs) begin
                        bus.pix_valid <= 1'b0;
                        bus.pix_last  <= 1'b0;
                        if (pix_idx == 6'd63) begin
                            state          <= LOAD;
                            load_cnt       <= '0;
                            bus.coef_ready <= 1'b1;
                            bus.busy       <= 1'b0;
                        end else begin
                            pix_idx <= pix_idx + 6'd1;
                            mac_cnt <= '0;
                            state   <= MAC;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_idct_8x8_engine.sv
// Self-checking bench for idct_8x8_engine against a floating-point IDCT reference model.
module tb_idct_8x8_engine;

    localparam int  COEF_W = 16;
    localparam real PI     = 3.14159265358979323846;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    idct_8x8_engine_if #(.COEF_W(COEF_W)) bus ();

    idct_8x8_engine #(
        .COEF_W   (COEF_W),
        .COS_FRAC (16),
        .ACC_W    (56)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_coef_cyc = 0;
    int coefs  [64];
    int px     [64];
    int px_ref [64];
    int px_cyc [64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input int got, input int expected, input int tol);
        checks++;
        if (got > expected + tol || got < expected - tol) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (tol %0d)", tag, got, expected, tol);
        end
    endtask

    // Reference: x = 1/4 * sum C(k1)C(k2) X cos((2n1+1)k1 pi/16) cos((2n2+1)k2 pi/16), round half-up, +128, clamp.
    function automatic int golden_pixel(input int n1, input int n2);
        real s, ck1, ck2, x;
        int  r;
        s = 0.0;
        for (int k1 = 0; k1 < 8; k1++) begin
            for (int k2 = 0; k2 < 8; k2++) begin
                ck1 = (k1 == 0) ? 0.7071067811865476 : 1.0;
                ck2 = (k2 == 0) ? 0.7071067811865476 : 1.0;
                s += ck1 * ck2 * real'(coefs[k1*8 + k2])
                     * $cos(real'((2*n1 + 1) * k1) * PI / 16.0)
                     * $cos(real'((2*n2 + 1) * k2) * PI / 16.0);
            end
        end
        x = s / 4.0;
        r = $rtoi($floor(x + 0.5)) + 128;
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    task automatic check_reset_state(input string tag);
        check_output({tag, "_coef_ready"}, int'(bus.coef_ready), 1, 0);
        check_output({tag, "_pix_valid"},  int'(bus.pix_valid),  0, 0);
        check_output({tag, "_pix_data"},   int'(bus.pix_data),   0, 0);
        check_output({tag, "_pix_last"},   int'(bus.pix_last),   0, 0);
        check_output({tag, "_busy"},       int'(bus.busy),       0, 0);
    endtask

    // Called just after a rising edge; sends coefs[0..n_coef-1], optionally with random valid gaps.
    task automatic apply_stimulus(input int n_coef, input bit gaps);
        int idx   = 0;
        int guard = 0;
        bit hs;
        while (idx < n_coef && guard < 2000) begin
            bus.coef_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.coef_data  = 16'(coefs[idx]);
            check_output("no_stale_pix", int'(bus.pix_valid), 0, 0);
            hs = bus.coef_valid && bus.coef_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                last_coef_cyc = cyc;
            end
            guard++;
        end
        bus.coef_valid = 1'b0;
        check_output("coef_count", idx, n_coef, 0);
    endtask

    task automatic collect_pixels(input int n_max, input bit stall);
        int got       = 0;
        int guard     = 0;
        int held_data = 0;
        bit held      = 1'b0;
        bit hs;
        while (got < n_max && guard < 20000) begin
            bus.pix_ready = stall ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (held) begin
                check_output("stall_valid", int'(bus.pix_valid), 1, 0);
                check_output("stall_data",  int'(bus.pix_data), held_data, 0);
            end
            if (stall && bus.busy)
                check_output("ready_while_busy", int'(bus.coef_ready), 0, 0);
            hs        = bus.pix_valid && bus.pix_ready;
            held      = bus.pix_valid && !bus.pix_ready;
            held_data = int'(bus.pix_data);
            if (hs) begin
                px[got] = int'(bus.pix_data);
                check_output("pix_last", int'(bus.pix_last), int'(got == 63), 0);
            end
            @(posedge clk);
            #1;
            if (hs) begin
                px_cyc[got] = cyc;
                got++;
            end
            guard++;
        end
        bus.pix_ready = 1'b0;
        check_output("pix_count", got, n_max, 0);
    endtask

    task automatic randomize_coefs();
        for (int i = 0; i < 64; i++)
            coefs[i] = int'($urandom_range(0, 120)) - 60;
        coefs[0] = int'($urandom_range(0, 400)) - 200;
    endtask

    task automatic check_against_golden(input string tag);
        for (int i = 0; i < 64; i++)
            check_output(tag, px[i], golden_pixel(i / 8, i % 8), 1);
    endtask

    int dc_vals [6] = '{800, 2000, -2000, 4, -4, 1024};
    int dc_exp  [6] = '{228,  255,     0, 129, 128, 255};

    initial begin
        bus.coef_valid = 1'b0;
        bus.coef_data  = '0;
        bus.pix_ready  = 1'b0;
        #12;
        check_reset_state("reset");
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All-zero block, also used to measure latency and per-pixel period.
        for (int i = 0; i < 64; i++) coefs[i] = 0;
        apply_stimulus(64, 1'b0);
        collect_pixels(64, 1'b0);
        for (int i = 0; i < 64; i++) check_output("zero_pix", px[i], 128, 0);
        check_output("first_latency", px_cyc[0] - last_coef_cyc, 66, 0);
        for (int i = 1; i < 64; i++) check_output("pix_period", px_cyc[i] - px_cyc[i-1], 66, 0);

        // DC-only blocks, including rounding ties and both saturation rails.
        for (int d = 0; d < 6; d++) begin
            for (int i = 0; i < 64; i++) coefs[i] = 0;
            coefs[0] = dc_vals[d];
            apply_stimulus(64, 1'b0);
            collect_pixels(64, 1'b0);
            for (int i = 0; i < 64; i++) check_output("dc_pix", px[i], dc_exp[d], 0);
        end

        // Single horizontal AC term.
        for (int i = 0; i < 64; i++) coefs[i] = 0;
        coefs[1] = 64;
        apply_stimulus(64, 1'b0);
        collect_pixels(64, 1'b0);
        check_against_golden("ac_golden");
        for (int i = 8; i < 64; i++) check_output("ac_rows_equal", px[i], px[i % 8], 0);
        for (int c = 0; c < 4; c++) check_output("ac_antisym", px[c] + px[7 - c], 256, 1);

        // Random block without stalls, then the same block with gaps and back-pressure.
        randomize_coefs();
        apply_stimulus(64, 1'b0);
        collect_pixels(64, 1'b0);
        check_against_golden("rand_golden");
        for (int i = 0; i < 64; i++) px_ref[i] = px[i];
        apply_stimulus(64, 1'b1);
        collect_pixels(64, 1'b1);
        for (int i = 0; i < 64; i++) check_output("stall_same_seq", px[i], px_ref[i], 0);

        // Abort in MAC while computing pixel 20.
        randomize_coefs();
        apply_stimulus(64, 1'b0);
        collect_pixels(20, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        check_output("mid_mac_busy", int'(bus.busy), 1, 0);
        rst_n = 1'b0;
        #1;
        check_reset_state("mac_abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        randomize_coefs();
        apply_stimulus(64, 1'b0);
        collect_pixels(64, 1'b0);
        check_against_golden("after_mac_abort");

        // Abort in LOAD after 30 coefficients.
        randomize_coefs();
        apply_stimulus(30, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("load_abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        randomize_coefs();
        apply_stimulus(64, 1'b0);
        collect_pixels(64, 1'b0);
        check_against_golden("after_load_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
